dmem_ctrl: RTL
==============

# dmem_ctrl

- Parametrised data memory for the RV64 core, succeeding the flat single-port word RAM.
- Adds byte addressing with B/H/W/D access sizes and byte-lane writes.
- Adds sign/zero-extended loads, misalignment faults, a registered read, and a valid/ready request/response handshake with back-pressure.
- Sits between the core's load/store unit and backing storage; one request in flight, one response per request.

## Interface
- `ADDR_W`, default 20: byte-address width.
- `DATA_W`, default 64: word width, 32 or 64. `BYTES = DATA_W/8`, `OFF_W = log2(BYTES)`, `DEPTH = 2**(ADDR_W-OFF_W)` words.
- Clocking is fixed: one clock; reset is asynchronous and active-low. Both ports are listed first.
- `clk` in 1: the single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: a request is presented.
- `req_ready` out 1: the block can accept a request this cycle.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 0 = B, 1 = H, 2 = W, 3 = D.
- `req_unsigned` in 1: zero-extend loads instead of sign-extending.
- `req_addr` in `ADDR_W`: byte address.
- `req_wdata` in `DATA_W`: store data, right-aligned (LSBs).
- `rsp_valid` out 1: a response is held.
- `rsp_ready` in 1: the consumer takes the response.
- `rsp_rdata` out `DATA_W`: load result, extended; 0 for stores and faults.
- `rsp_fault` out 1: misaligned or illegal-size access.
- `init_done` out 1: memory is usable.

## Operation
- Handshake:
  - A request is accepted on an edge with `req_valid && req_ready`.
  - A response completes on an edge with `rsp_valid && rsp_ready`.
- States:
  - INIT (only with the macro), IDLE, RESP.
  - IDLE: `req_ready` = 1. On accept → RESP.
  - RESP: `rsp_valid` = 1; `rsp_rdata` and `rsp_fault` are held stable until `rsp_ready`.
    - `rsp_ready` with no new accept → IDLE.
    - `rsp_ready` with a new accept in the same cycle → stays RESP with the new response (back-to-back, 1 access/cycle).
  - `req_ready` = (IDLE) || (RESP && `rsp_ready`). It is 0 in INIT.
- Fault: `req_addr` not a multiple of 2^`req_size`, or `req_size` = 3 with `DATA_W` = 32.
  - No memory write; response is `rsp_fault` = 1, `rsp_rdata` = 0.
- Store:
  - Word index = `req_addr[ADDR_W-1:OFF_W]`.
  - Lane mask = (2^`size` ones) << `req_addr[OFF_W-1:0]`.
  - Data is shifted left by 8×offset; only masked bytes are written on the accept edge.
  - Response: `rsp_fault` = 0, `rsp_rdata` = 0.
- Load:
  - The word is read at the accept edge and shifted right by 8×offset.
  - It is truncated to the access size, then sign-extended (bit 8·2^size−1) or zero-extended to `DATA_W`.
- Read-after-write: a load accepted the cycle after a store to the same word returns the new bytes.
- Memory contents are never touched by reset.

## Timing
- Reset values:
  - `req_ready` 0 with the macro, 1 without.
  - `rsp_valid` 0, `rsp_rdata` 0, `rsp_fault` 0.
  - `init_done` 0 with the macro, 1 without.
  - State is INIT or IDLE; init counter 0.
- Latency: the response is valid in the cycle after the accept edge, for both loads and stores.
- Reset asserted mid-operation: the pending response is dropped, and the INIT sweep restarts from word 0.
- `rsp_valid` never drops without `rsp_ready`.

## Configuration
- `DMEM_INIT_CLEAR_EN` defined:
  - After reset, INIT writes zero to word 0..`DEPTH`-1, one word per cycle.
  - The counter is `ADDR_W-OFF_W` bits; on the last word it moves to IDLE and sets `init_done` = 1.
  - INIT takes exactly `DEPTH` cycles, during which requests are not accepted.
- `DMEM_INIT_CLEAR_EN` undefined:
  - No INIT state; the block starts in IDLE and `init_done` is tied to 1.
  - Contents come from `$readmemh` preload of the instruction image path.

## Structure
- `dmem_pkg`:
  - `size_e` (SZ_B, SZ_H, SZ_W, SZ_D).
  - `state_e` (ST_INIT, ST_IDLE, ST_RESP).
  - Function computing the lane mask from size and offset.
- Sub-module `dmem_lane_align`, combinational, parametrised by `DATA_W`:
  - Store path: produces the shifted write data and byte mask.
  - Load path: extracts and extends the load result; flags misalignment.

## Test plan
Parameters for all cases: `DATA_W` = 64, `ADDR_W` = 12.

- Reset/init:
  - With the macro: `init_done` rises after exactly 512 cycles.
  - A D load from 0x1F8 returns 0.
  - `req_ready` stays 0 throughout INIT.
- Byte store then signed load:
  - Store B 0x80 to 0x103, then load B signed from 0x103 → 0xFFFF_FFFF_FFFF_FF80.
  - The same load unsigned → 0x80.
  - Bytes 0x100–0x102 and 0x104–0x107 are unchanged.
- Misaligned access:
  - Store H to 0x101 → `rsp_fault` = 1, `rsp_rdata` = 0.
  - A following D load of word 0x100 shows no change.
- Back-pressure:
  - Hold `rsp_ready` = 0 for 5 cycles after a W load of 0x200 (contents 0x8765_4321) → `rsp_rdata` stays 0xFFFF_FFFF_8765_4321.
  - `req_ready` = 0 throughout.
- Back-to-back:
  - Run 4 consecutive accepts with `rsp_ready` = 1: store D 0x1122334455667788 to 0x40, then load D, W, H at 0x40.
  - Required responses, one per cycle: 0, 0x1122334455667788, 0x55667788, 0x7788.
- Reset mid-RESP and mid-INIT:
  - Pulse `rst_n` low → `rsp_valid` drops immediately.
  - With the macro, INIT restarts and again takes 512 cycles.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the dmem_ctrl data memory.
// Optional feature macro: DMEM_INIT_CLEAR_EN (zero-fill sweep after reset).
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // 2^size contiguous byte lanes starting at byte offset 'off' (up to 8 lanes)
    function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [2:0] off);
        logic [7:0] ones;
        case (size)
            SZ_B:    ones = 8'h01;
            SZ_H:    ones = 8'h03;
            SZ_W:    ones = 8'h0F;
            default: ones = 8'hFF;
        endcase
        return ones << off;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane alignment for dmem_ctrl: shifts store data into lanes, builds the
// byte-enable mask, extracts and extends load data, and flags bad accesses.
module dmem_lane_align
    import dmem_pkg::*;
#(
    parameter int DATA_W = 64,
    localparam int BYTES = DATA_W / 8,
    localparam int OFF_W = $clog2(BYTES)
) (
    input  logic [1:0]        size_i,
    input  logic [OFF_W-1:0]  off_i,
    input  logic              unsigned_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [DATA_W-1:0] rword_i,
    output logic [DATA_W-1:0] wdata_o,
    output logic [BYTES-1:0]  be_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              fault_o
);

    logic [2:0]        off3;
    logic [7:0]        mask8;
    logic [DATA_W-1:0] sh;
    logic [DATA_W-1:0] keep;
    logic              sgn;
    logic              misalign;
    logic              size_bad;

    assign off3     = 3'(off_i);
    assign mask8    = lane_mask(size_i, off3);
    assign be_o     = mask8[BYTES-1:0];
    assign wdata_o  = wdata_i << {off_i, 3'b000};
    assign sh       = rword_i >> {off_i, 3'b000};
    // 64-bit accesses do not exist on a 32-bit memory
    assign size_bad = (size_i == SZ_D) && (DATA_W == 32);
    assign fault_o  = misalign | size_bad;

    // Alignment check and per-size truncation mask / sign bit for loads
    always_comb begin
        misalign = 1'b0;
        keep     = '1;
        sgn      = 1'b0;
        case (size_i)
            SZ_B: begin
                keep = DATA_W'(8'hFF);
                sgn  = sh[7];
            end
            SZ_H: begin
                misalign = off3[0];
                keep     = DATA_W'(16'hFFFF);
                sgn      = sh[15];
            end
            SZ_W: begin
                misalign = |off3[1:0];
                keep     = DATA_W'(32'hFFFF_FFFF);
                sgn      = sh[31];
            end
            default: begin
                misalign = |off3;
            end
        endcase
    end

    assign rdata_o = (sh & keep) | ((!unsigned_i && sgn) ? ~keep : '0);

endmodule

// File: rtl/dmem_ctrl.sv
// Byte-addressed data memory with B/H/W/D accesses, valid/ready request and
// response handshakes, one request in flight, registered read.
// Optional feature macro: DMEM_INIT_CLEAR_EN -- when defined, an INIT state
// zero-fills every word after reset before requests are accepted; otherwise
// the memory image is expected to be preloaded externally into mem_q.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_fault,
    output logic              init_done
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int IDX_W = ADDR_W - OFF_W;
    localparam int DEPTH = 2 ** IDX_W;

    logic [DATA_W-1:0] mem_q [DEPTH];

    state_e            state_q, state_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              fault_q, fault_d;

    logic [IDX_W-1:0]  idx;
    logic [OFF_W-1:0]  off;
    logic              accept;
    logic              wr_en;
    logic [DATA_W-1:0] wdata_sh;
    logic [BYTES-1:0]  be;
    logic [DATA_W-1:0] ld_ext;
    logic              acc_fault;

`ifdef DMEM_INIT_CLEAR_EN
    logic [IDX_W-1:0]  icnt_q, icnt_d;
`endif

    assign idx    = req_addr[ADDR_W-1:OFF_W];
    assign off    = req_addr[OFF_W-1:0];
    assign accept = req_valid && req_ready;
    assign wr_en  = accept && req_we && !acc_fault;

    dmem_lane_align #(.DATA_W(DATA_W)) u_align (
        .size_i     (req_size),
        .off_i      (off),
        .unsigned_i (req_unsigned),
        .wdata_i    (req_wdata),
        .rword_i    (mem_q[idx]),
        .wdata_o    (wdata_sh),
        .be_o       (be),
        .rdata_o    (ld_ext),
        .fault_o    (acc_fault)
    );

    // Next state, handshake outputs and init sweep counter
    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
`ifdef DMEM_INIT_CLEAR_EN
        icnt_d    = icnt_q;
`endif
        case (state_q)
            ST_INIT: begin
`ifdef DMEM_INIT_CLEAR_EN
                icnt_d = icnt_q + IDX_W'(1);
                if (icnt_q == '1) state_d = ST_IDLE;
`else
                state_d = ST_IDLE;
`endif
            end
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_d = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                // a completing response frees the slot for a same-cycle accept
                req_ready = rsp_ready;
                if (rsp_ready && !req_valid) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Response payload is captured on accept and held until the next accept
    always_comb begin
        rdata_d = rdata_q;
        fault_d = fault_q;
        if (accept) begin
            fault_d = acc_fault;
            rdata_d = (acc_fault || req_we) ? '0 : ld_ext;
        end
    end

    // Control and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
`ifdef DMEM_INIT_CLEAR_EN
            state_q <= ST_INIT;
            icnt_q  <= '0;
`else
            state_q <= ST_IDLE;
`endif
            rdata_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
`ifdef DMEM_INIT_CLEAR_EN
            icnt_q  <= icnt_d;
`endif
            rdata_q <= rdata_d;
            fault_q <= fault_d;
        end
    end

    // Storage array: byte-lane stores, plus the zero sweep in INIT; no reset
    always_ff @(posedge clk) begin
`ifdef DMEM_INIT_CLEAR_EN
        if (state_q == ST_INIT) mem_q[icnt_q] <= '0;
`endif
        for (int b = 0; b < BYTES; b++) begin
            if (wr_en && be[b]) mem_q[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
        end
    end

    assign rsp_rdata = rdata_q;
    assign rsp_fault = fault_q;
`ifdef DMEM_INIT_CLEAR_EN
    assign init_done = (state_q != ST_INIT);
`else
    assign init_done = 1'b1;
`endif

endmodule
